// File: rtl/lcd_pkg.sv
// Shared LCD command codes, scheduler state type and window-byte helper
// for the tile refresh scheduler.
package lcd_pkg;

   localparam logic [7:0] LCD_CASET = 8'h2A;
   localparam logic [7:0] LCD_PASET = 8'h2B;
   localparam logic [7:0] LCD_RAMWR = 8'h2C;

   typedef logic [15:0] rgb565_t;

   typedef enum logic [3:0] {
      IDLE,
      CASET_CMD,
      CASET_D,
      PASET_CMD,
      PASET_D,
      RAMWR_CMD,
      PIX_HI,
      PIX_LO,
      NEXT_TILE,
      DONE
   } sched_state_t;

   // Byte idx of the 16-bit window {start, end} for one tile, MSB first.
   function automatic logic [7:0] window_byte(input logic [3:0] tile,
                                              input int unsigned tile_px,
                                              input logic [1:0] idx);
      logic [15:0] lo;
      logic [15:0] hi;
      logic [7:0]  res;
      lo = 16'(tile) * 16'(tile_px);
      hi = lo + 16'(tile_px - 1);
      case (idx)
         2'd0:    res = lo[15:8];
         2'd1:    res = lo[7:0];
         2'd2:    res = hi[15:8];
         default: res = hi[7:0];
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// 8080-style byte strobe: drives D/dcx with wr low then high for a fixed
// number of cycles; ready in its last high cycle so bytes run back to back.
module lcd_byte_writer #(
   parameter int WR_LOW_CYC  = 1,
   parameter int WR_HIGH_CYC = 1
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       byte_dcx,
   output logic       byte_ready,
   output logic [7:0] D,
   output logic       dcx,
   output logic       wr
);

   localparam int MAX_CYC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {W_IDLE, W_LOW, W_HIGH} wr_state_t;

   wr_state_t     st;
   logic [CW-1:0] cnt;

   assign byte_ready = (st == W_IDLE) || (st == W_HIGH && cnt == CW'(WR_HIGH_CYC - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         st  <= W_IDLE;
         cnt <= '0;
         D   <= '0;
         dcx <= 1'b0;
         wr  <= 1'b1;
      end else if (byte_valid && byte_ready) begin
         st  <= W_LOW;
         cnt <= '0;
         D   <= byte_data;
         dcx <= byte_dcx;
         wr  <= 1'b0;
      end else begin
         unique case (st)
            W_LOW:
               if (cnt == CW'(WR_LOW_CYC - 1)) begin
                  st  <= W_HIGH;
                  cnt <= '0;
                  wr  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            W_HIGH:
               if (cnt == CW'(WR_HIGH_CYC - 1)) st <= W_IDLE;
               else                             cnt <= cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/tile_refresh_scheduler.sv
// Repaints the GRID_W x GRID_H tile field over the LCD bus, one window + RAMWR per tile.
// Optional DIRTY_MAP_EN adds a per-tile dirty bitmap so clean tiles are skipped.
module tile_refresh_scheduler
   import lcd_pkg::*;
#(
   parameter int GRID_W      = 16,
   parameter int GRID_H      = 12,
   parameter int TILE_PX     = 20,
   parameter int WR_LOW_CYC  = 1,
   parameter int WR_HIGH_CYC = 1
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       start,
   input  rgb565_t    pix_color,
`ifdef DIRTY_MAP_EN
   input  logic       mark_dirty,
   input  logic [3:0] mark_x,
   input  logic [3:0] mark_y,
`endif
   output logic [3:0] x,
   output logic [3:0] y,
   output logic [7:0] D,
   output logic       dcx,
   output logic       wr,
   output logic       busy,
   output logic       frame_done
);

   localparam int PIX_N = TILE_PX * TILE_PX;
   localparam int PCW   = $clog2(PIX_N + 1);

   sched_state_t   state, state_n;
   logic [3:0]     x_n, y_n, ent_x, ent_y;
   logic [1:0]     bcnt, bcnt_n;
   logic [PCW-1:0] px_cnt, px_cnt_n;
   logic [7:0]     pix_lo;
   logic           pix_load, dirty_clr, tile_end, enter, ent_dirty;
   logic           last_col, last_tile;
   logic           byte_valid, byte_ready, byte_dcx;
   logic [7:0]     byte_data;

   assign last_col  = (x == 4'(GRID_W - 1));
   assign last_tile = last_col && (y == 4'(GRID_H - 1));
   assign ent_x     = (state == IDLE || last_col) ? 4'd0 : x + 4'd1;
   assign ent_y     = (state == IDLE) ? 4'd0 : (last_col ? y + 4'd1 : y);

`ifdef DIRTY_MAP_EN
   localparam int NT = GRID_W * GRID_H;
   localparam int IW = $clog2(NT);

   logic [NT-1:0] dirty;

   function automatic logic [IW-1:0] tile_idx(input logic [3:0] tx, input logic [3:0] ty);
      return IW'(int'(ty) * GRID_W + int'(tx));
   endfunction

   assign ent_dirty = dirty[tile_idx(ent_x, ent_y)];

   // NOTE: the bitmap is plain flops, not a RAM, so it is safe to give it an async reset value.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dirty <= '1;
      end else begin
         if (dirty_clr)  dirty[tile_idx(x, y)]           <= 1'b0;
         if (mark_dirty) dirty[tile_idx(mark_x, mark_y)] <= 1'b1;
      end
   end
`else
   assign ent_dirty = 1'b1;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_n    = state;
      x_n        = x;
      y_n        = y;
      bcnt_n     = bcnt;
      px_cnt_n   = px_cnt;
      byte_valid = 1'b0;
      byte_data  = '0;
      byte_dcx   = 1'b0;
      pix_load   = 1'b0;
      dirty_clr  = 1'b0;
      tile_end   = 1'b0;
      enter      = 1'b0;

      // Each state names the byte currently on the bus; the next one is offered on byte_ready.
      unique case (state)
         IDLE:      enter = start;
         CASET_CMD, PASET_CMD:
            if (byte_ready) begin
               byte_valid = 1'b1;
               byte_dcx   = 1'b1;
               byte_data  = window_byte((state == CASET_CMD) ? x : y, TILE_PX, bcnt);
               bcnt_n     = bcnt + 2'd1;
               state_n    = (state == CASET_CMD) ? CASET_D : PASET_D;
            end
         CASET_D, PASET_D:
            if (byte_ready) begin
               byte_valid = 1'b1;
               if (bcnt != 2'd0) begin
                  byte_dcx  = 1'b1;
                  byte_data = window_byte((state == CASET_D) ? x : y, TILE_PX, bcnt);
                  bcnt_n    = bcnt + 2'd1;
               end else if (state == CASET_D) begin
                  byte_data = LCD_PASET;
                  state_n   = PASET_CMD;
               end else begin
                  byte_data = LCD_RAMWR;
                  dirty_clr = 1'b1;
                  px_cnt_n  = '0;
                  state_n   = RAMWR_CMD;
               end
            end
         RAMWR_CMD:
            if (byte_ready) begin
               byte_valid = 1'b1;
               byte_dcx   = 1'b1;
               byte_data  = pix_color[15:8];
               pix_load   = 1'b1;
               state_n    = PIX_HI;
            end
         PIX_HI:
            if (byte_ready) begin
               byte_valid = 1'b1;
               byte_dcx   = 1'b1;
               byte_data  = pix_lo;
               state_n    = PIX_LO;
            end
         PIX_LO:
            if (byte_ready) begin
               if (px_cnt == PCW'(PIX_N - 1)) begin
                  tile_end = 1'b1;
               end else begin
                  byte_valid = 1'b1;
                  byte_dcx   = 1'b1;
                  byte_data  = pix_color[15:8];
                  pix_load   = 1'b1;
                  px_cnt_n   = px_cnt + 1'b1;
                  state_n    = PIX_HI;
               end
            end
         NEXT_TILE: tile_end = 1'b1;
         DONE:      state_n  = IDLE;
         default:   state_n  = IDLE;
      endcase

      if (tile_end) begin
         if (last_tile) begin
            state_n = DONE;
            x_n     = 4'd0;
            y_n     = 4'd0;
         end else begin
            enter = 1'b1;
         end
      end

      if (enter) begin
         x_n    = ent_x;
         y_n    = ent_y;
         bcnt_n = 2'd0;
         if (ent_dirty && byte_ready) begin
            byte_valid = 1'b1;
            byte_data  = LCD_CASET;
            state_n    = CASET_CMD;
         end else begin
            state_n = NEXT_TILE;
         end
      end
   end

   // The high byte goes to the bus on the edge the colour is sampled; only the low half waits.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state  <= IDLE;
         x      <= '0;
         y      <= '0;
         bcnt   <= '0;
         px_cnt <= '0;
         pix_lo <= '0;
      end else begin
         state  <= state_n;
         x      <= x_n;
         y      <= y_n;
         bcnt   <= bcnt_n;
         px_cnt <= px_cnt_n;
         if (pix_load) pix_lo <= pix_color[7:0];
      end
   end

   assign busy       = (state != IDLE) && (state != DONE);
   assign frame_done = (state == DONE);

   lcd_byte_writer #(
      .WR_LOW_CYC  (WR_LOW_CYC),
      .WR_HIGH_CYC (WR_HIGH_CYC)
   ) u_writer (
      .clk        (clk),
      .nrst       (nrst),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_dcx   (byte_dcx),
      .byte_ready (byte_ready),
      .D          (D),
      .dcx        (dcx),
      .wr         (wr)
   );

endmodule
